// File: rtl/mux_round_robin_arbiter.sv
// Round-robin arbiter that owns the select lines of a 4:1 mux shared by four requesters.
// Grants are held across multi-cycle transfers and revoked after MAX_HOLD cycles.
module mux_round_robin_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic       address0,
    output logic       address1,
    output logic       busy,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [3:0]       grant_d;
    logic [1:0]       addr_q, addr_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_d;

    logic [3:0] owner_bit;
    logic       owner_done;
    logic       owner_req;
    logic       expired;
    logic       release_now;
    logic [3:0] eligible;
    logic [3:0] candidates;
    logic [1:0] winner;

    // First set bit of r, scanning circularly upward from start.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // In GRANT the owner is always last_q, so it doubles as the owner index.
    assign owner_bit   = 4'b0001 << last_q;
    assign owner_done  = done[last_q];
    assign owner_req   = req[last_q];
    assign expired     = (cnt_q == HOLD_LIMIT);
    assign release_now = owner_done | ~owner_req | expired;

    // A finished or expired owner may not win its own hand-over.
    assign eligible   = (owner_done | expired) ? (req & ~owner_bit) : req;
    assign candidates = (state_q == ST_IDLE) ? req : eligible;
    assign winner     = rr_pick(candidates, last_q + 2'd1);

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        addr_d    = addr_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    grant_d = 4'b0001 << winner;
                    addr_d  = winner;
                    last_d  = winner;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                if (!release_now) begin
                    if (cnt_q != HOLD_LIMIT) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    timeout_d = expired & ~owner_done & owner_req;
                    if (|eligible) begin
                        grant_d = 4'b0001 << winner;
                        addr_d  = winner;
                        last_d  = winner;
                        cnt_d   = CNT_ONE;
                    end else begin
                        // Address keeps the old owner so the mux output stays stable while idle.
                        state_d = ST_IDLE;
                        grant_d = 4'b0000;
                    end
                end
            end
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant   <= 4'b0000;
            addr_q  <= 2'b00;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            timeout <= timeout_d;
        end
    end

    assign address0 = addr_q[0];
    assign address1 = addr_q[1];
    assign busy     = |grant;

endmodule

// File: tb/tb_mux_round_robin_arbiter.sv
// Randomised and directed bench for mux_round_robin_arbiter against a cycle-level
// behavioural model of the ownership rules.
module tb_mux_round_robin_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] done = 4'b0000;
    logic [3:0] grant;
    logic       address0;
    logic       address1;
    logic       busy;
    logic       timeout;

    mux_round_robin_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .address0 (address0),
        .address1 (address1),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: owner index (-1 = nobody), priority pointer, hold count, mux select, timeout flag.
    int m_owner;
    int m_last;
    int m_cnt;
    int m_addr;
    bit m_tout;

    logic [7:0] obs;
    logic [7:0] exp_vec;
    assign obs = {grant, address1, address0, busy, timeout};

    function automatic int pick(input logic [3:0] r, input int start);
        int idx;
        for (int d = 0; d < 4; d++) begin
            idx = (start + d) % 4;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_vec();
        logic [3:0] g;
        int         a;
        g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        a = m_addr;
        return {g, a[1:0], (m_owner >= 0), m_tout};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_cnt   = 0;
        m_addr  = 0;
        m_tout  = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] elig;
        int         k;
        bit         expd;
        m_tout = 1'b0;
        if (m_owner < 0) begin
            if (req != 4'b0000) begin
                m_owner = pick(req, (m_last + 1) % 4);
                m_last  = m_owner;
                m_addr  = m_owner;
                m_cnt   = 1;
            end
        end else begin
            k    = m_owner;
            expd = (m_cnt == MAX_HOLD);
            if (!done[k] && req[k] && !expd) begin
                if (m_cnt < MAX_HOLD) m_cnt++;
            end else begin
                m_tout = expd && !done[k] && req[k];
                elig   = req;
                if (done[k] || expd) elig[k] = 1'b0;
                if (elig != 4'b0000) begin
                    m_owner = pick(elig, (k + 1) % 4);
                    m_last  = m_owner;
                    m_addr  = m_owner;
                    m_cnt   = 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        done    = 4'b0000;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b1111;
        done    = 4'b0000;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got %b, expected %b", obs, 8'h00);
        end
        @(negedge clk);
        req     = 4'b0000;
        reset_n = 1'b1;
        tick();
        exp_vec = model_vec();
        checks++;
        if (obs !== exp_vec) begin
            errors++;
            $display("FAIL reset_idle: got %b, expected %b", obs, exp_vec);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0001;
        for (int t = 1; t <= 6; t++) begin
            done = (t == 4) ? 4'b0001 : 4'b0000;
            tick();
            exp_vec = model_vec();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL single_model t=%0d: got %b, expected %b", t, obs, exp_vec);
            end
            if (t == 1 || t == 4) begin
                checks++;
                if (obs !== ((t == 1) ? 8'b0001_00_1_0 : 8'b0000_00_0_0)) begin
                    errors++;
                    $display("FAIL single_direct t=%0d: got %b, expected %b", t, obs,
                             (t == 1) ? 8'b0001_00_1_0 : 8'b0000_00_0_0);
                end
            end
        end
        done = 4'b0000;
    endtask

    task automatic test_rotate();
        int own;
        apply_reset();
        req = 4'b1111;
        for (int t = 1; t <= 10; t++) begin
            done = (t >= 3 && (t % 2) == 1) ? (4'b0001 << (((t - 2) / 2) % 4)) : 4'b0000;
            tick();
            own = ((t - 1) / 2) % 4;
            exp_vec = model_vec();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL rotate_model t=%0d: got %b, expected %b", t, obs, exp_vec);
            end
            checks++;
            if (grant !== (4'b0001 << own) || {address1, address0} !== own[1:0]) begin
                errors++;
                $display("FAIL rotate_owner t=%0d: got grant=%b addr=%b, expected owner %0d",
                         t, grant, {address1, address0}, own);
            end
        end
        done = 4'b0000;
    endtask

    task automatic test_timeout();
        int own;
        int pulses;
        pulses = 0;
        apply_reset();
        req = 4'b0011;
        for (int t = 1; t <= 17; t++) begin
            tick();
            own = (t <= 8) ? 0 : ((t <= 16) ? 1 : 0);
            if (timeout === 1'b1) pulses++;
            exp_vec = model_vec();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL timeout_model t=%0d: got %b, expected %b", t, obs, exp_vec);
            end
            checks++;
            if (grant !== (4'b0001 << own) || timeout !== (t == 9 || t == 17)) begin
                errors++;
                $display("FAIL timeout_direct t=%0d: got grant=%b timeout=%b, expected owner %0d timeout %0d",
                         t, grant, timeout, own, (t == 9 || t == 17));
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d, expected 2", pulses);
        end
    endtask

    task automatic test_drop();
        apply_reset();
        req = 4'b0100;
        tick();
        req = 4'b1100;
        tick();
        tick();
        exp_vec = model_vec();
        checks++;
        if (obs !== exp_vec || grant !== 4'b0100) begin
            errors++;
            $display("FAIL drop_hold: got %b, expected %b", obs, exp_vec);
        end
        req = 4'b1000;
        tick();
        exp_vec = model_vec();
        checks++;
        if (obs !== exp_vec || obs !== 8'b1000_11_1_0) begin
            errors++;
            $display("FAIL drop_handover: got %b, expected %b", obs, 8'b1000_11_1_0);
        end
    endtask

    task automatic test_simul();
        apply_reset();
        req = 4'b0001;
        for (int t = 1; t <= 13; t++) begin
            done = (t == 9) ? 4'b0001 : ((t >= 11) ? 4'b1110 : 4'b0000);
            tick();
            exp_vec = model_vec();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL simul_model t=%0d: got %b, expected %b", t, obs, exp_vec);
            end
            if (t == 9 || t >= 11) begin
                checks++;
                if (obs !== ((t == 9) ? 8'b0000_00_0_0 : 8'b0001_00_1_0)) begin
                    errors++;
                    $display("FAIL simul_direct t=%0d: got %b, expected %b", t, obs,
                             (t == 9) ? 8'b0000_00_0_0 : 8'b0001_00_1_0);
                end
            end
        end
        done = 4'b0000;
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b0010;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %b, expected %b", obs, 8'h00);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        req     = 4'b1000;
        tick();
        exp_vec = model_vec();
        checks++;
        if (obs !== exp_vec || obs !== 8'b1000_11_1_0) begin
            errors++;
            $display("FAIL async_regrant: got %b, expected %b", obs, 8'b1000_11_1_0);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            done = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
            tick();
            exp_vec = model_vec();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random t=%0d req=%b done=%b: got %b, expected %b",
                         t, req, done, obs, exp_vec);
            end
        end
        req  = 4'b0000;
        done = 4'b0000;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rotate();
        test_timeout();
        test_drop();
        test_simul();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux_round_robin_arbiter.md
Name: mux_round_robin_arbiter

Overview:
Round-robin arbiter that shares one 4:1 multiplexer datapath among four requesters. It drives the mux select lines address1:address0 with the index of the current owner and returns a one-hot grant. Ownership is held across multi-cycle transfers. A hold limit prevents any requester from starving the others. It sits directly in front of the structural 4:1 mux; the mux data inputs in0..in3 come from requesters 0..3.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant; legal range 1..15.
CNT_W, 4, width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
req  input  4  request vector; bit i high means requester i wants the mux.
done  input  4  end-of-transfer strobe; bit i is sampled only while requester i holds the grant.
grant  output  4  one-hot ownership vector, registered; 4'b0000 when idle.
address0  output  1  mux select LSB; equals bit 0 of the owner index, registered.
address1  output  1  mux select MSB; equals bit 1 of the owner index, registered.
busy  output  1  high while any grant bit is high.
timeout  output  1  one-cycle pulse when a grant is revoked by hold-limit expiry.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, grant=0000, address1:address0=00, busy=0, timeout=0, hold counter=0, priority pointer last=3. With last=3, requester 0 has highest priority after reset. Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge.
- Winner selection: search req circularly starting at (last+1) mod 4; the first set bit wins.
- IDLE: on an edge with req!=0, register the winner. In the next cycle:
  - grant=onehot(winner), address=winner, busy=1.
  - last<=winner, counter<=1, state=GRANT.
  - Latency from req to grant: 1 cycle.
- GRANT (owner k): release condition R = done[k] | ~req[k] | (counter==MAX_HOLD).
  - R false: hold grant and address; counter increments and saturates at MAX_HOLD.
  - R true and (req with bit k masked off when done[k] or counter expiry caused R) != 0: hand over directly to the next winner, with no idle cycle. The search starts at (k+1) mod 4. last<=new winner, counter<=1.
  - R true and no eligible requester: state=IDLE, grant=0000, busy=0. address1:address0 keep the last owner value, so the mux output stays stable.
  - Sole requester re-grant: if k is the only requester and it keeps req high after done or after expiry, it is re-granted on the next cycle after exactly one idle cycle. Other requesters never see an idle gap.
- timeout: pulses high for the single cycle following a release caused only by counter==MAX_HOLD. If done[k] is high in the same cycle, done takes precedence and timeout stays 0.
- done bits of non-owners are ignored. Changes to req of non-owners during GRANT have no effect until the next release.
- Invariants: grant is one-hot or zero. When busy=1, address1:address0 always equals the index of the set grant bit.
- MAX_HOLD=1: every grant lasts exactly one cycle. With all four requesting, grants rotate 0,1,2,3,0,...

Test Plan:
- Reset then req=0001 held and done[0] pulsed in the 3rd grant cycle -> grant=0001 and addr=00 one cycle after req. Grant holds 3 cycles, then grant=0000, busy=0, addr stays 00, timeout=0.
- req=1111 held, done of the owner pulsed each grant's 2nd cycle -> owners rotate 0,1,2,3,0, each for 2 cycles with back-to-back grants. Addr tracks 00,01,10,11,00.
- MAX_HOLD=8, req=0011 held, no done -> requester 0 granted for 8 cycles, timeout pulses once, and requester 1 is granted on the next cycle. Requester 1 is then revoked after 8 cycles and requester 0 regains the grant.
- Owner 2 drops req mid-grant while req[3] is high -> grant moves 0100->1000 on the next edge, addr 10->11, timeout=0.
- Simultaneous events: done[k] and counter==MAX_HOLD in the same cycle -> release with timeout=0. A done on a non-owner bit -> no change.
- reset_n driven low mid-grant, between clock edges -> grant=0000, busy=0, addr=00 immediately. After release, req=1000 -> requester 3 granted, since last=3 makes the search start at 0 and 3 is the first set bit.
